// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and lane-permutation index for the
// 5x5 matrix line codec.
package matrix_pkg;

    localparam int unsigned LINE_W = 32'd25;
    localparam int unsigned DIM    = 32'd5;
    localparam int unsigned DEPTH  = 32'd64;
    localparam int unsigned AW     = 32'd6;

    // Highest buffer index; writing here always closes the frame.
    localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 32'd1);

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Encoder lane i is carried on wire f(i); decoding reads it back from there.
    function automatic int unsigned pi_index(input int unsigned i);
        int unsigned x;
        int unsigned y;
        int unsigned nx;
        int unsigned ny;
        x  = ((i % DIM) + 32'd3) % DIM;
        y  = ((i / DIM) + 32'd3) % DIM;
        nx = (y + 32'd2) % DIM;
        ny = (((32'd2 * x) + (32'd3 * y)) % DIM + 32'd2) % DIM;
        return (DIM * ny) + nx;
    endfunction

endpackage

// File: rtl/matrix_decoder_unswap.sv
// Inverse lane permutation: pure wiring, each output lane picks one input lane.
module matrix_decoder_unswap
    import matrix_pkg::*;
(
    input  logic [LINE_W-1:0] enc_line,
    output logic [LINE_W-1:0] dec_line
);

    for (genvar i = 0; i < LINE_W; i++) begin : g_lane
        localparam int unsigned SRC = pi_index(i);
        assign dec_line[i] = enc_line[SRC];
    end

endmodule

// File: rtl/matrix_decoder.sv
// Frame buffer + reverse-order drain with inverse lane permutation.
// Lines are loaded into a register buffer, then emitted LIFO once the frame
// closes; load and drain never overlap.
module matrix_decoder
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_line,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_line,
    output logic              out_last,
    output logic [AW:0]       frame_len,
    output logic              frame_err
);

    state_e            state_q;
    state_e            state_d;
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     wptr_d;
    logic [AW-1:0]     rptr_q;
    logic [AW-1:0]     rptr_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [LINE_W-1:0] out_line_q;
    logic [LINE_W-1:0] out_line_d;
    logic              out_last_q;
    logic              out_last_d;
    logic [AW:0]       frame_len_q;
    logic [AW:0]       frame_len_d;
    logic              frame_err_q;
    logic              frame_err_d;

    logic [LINE_W-1:0] mem_q [DEPTH];

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              close_s;
    logic              rptr_zero_s;
    logic [AW-1:0]     rptr_next_s;
    logic [LINE_W-1:0] unswap_in_s;
    logic [LINE_W-1:0] unswap_out_s;

    // Handshake qualification and the line fed to the unswap network.
    always_comb begin
        in_xfer_s   = (state_q == ST_LOAD) && in_valid && in_ready_q;
        out_xfer_s  = (state_q == ST_DRAIN) && out_valid_q && out_ready;
        close_s     = in_xfer_s && (in_last || (wptr_q == PTR_MAX));
        rptr_zero_s = (rptr_q == {AW{1'b0}});
        rptr_next_s = rptr_q - {{(AW-1){1'b0}}, 1'b1};
        // While loading, the closing line bypasses the buffer (it is written on
        // the same edge it becomes the first output).
        if (state_q == ST_LOAD) begin
            unswap_in_s = in_line;
        end else begin
            unswap_in_s = mem_q[rptr_next_s];
        end
    end

    matrix_decoder_unswap u_unswap (
        .enc_line (unswap_in_s),
        .dec_line (unswap_out_s)
    );

    // Next-state logic for the load/drain controller and its registered outputs.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_line_d  = out_line_q;
        out_last_d  = out_last_q;
        frame_len_d = frame_len_q;
        frame_err_d = frame_err_q;
        case (state_q)
            ST_LOAD: begin
                if (close_s) begin
                    state_d     = ST_DRAIN;
                    in_ready_d  = 1'b0;
                    wptr_d      = {AW{1'b0}};
                    rptr_d      = wptr_q;
                    frame_len_d = {1'b0, wptr_q} + {{AW{1'b0}}, 1'b1};
                    out_valid_d = 1'b1;
                    out_line_d  = unswap_out_s;
                    out_last_d  = (wptr_q == {AW{1'b0}});
                    // Error when a short frame ends early or a full one lacks in_last.
                    frame_err_d = frame_err_q | (in_last ^ (wptr_q == PTR_MAX));
                end else if (in_xfer_s) begin
                    wptr_d     = wptr_q + {{(AW-1){1'b0}}, 1'b1};
                    in_ready_d = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_xfer_s) begin
                    if (rptr_zero_s) begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_line_d  = {LINE_W{1'b0}};
                        in_ready_d  = 1'b1;
                    end else begin
                        rptr_d     = rptr_next_s;
                        out_line_d = unswap_out_s;
                        out_last_d = (rptr_next_s == {AW{1'b0}});
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                wptr_d      = {AW{1'b0}};
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_line_d  = {LINE_W{1'b0}};
            end
        endcase
    end

    // Controller state, pointers and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_line_q  <= {LINE_W{1'b0}};
            out_last_q  <= 1'b0;
            frame_len_q <= {(AW+1){1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_line_q  <= out_line_d;
            out_last_q  <= out_last_d;
            frame_len_q <= frame_len_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Line buffer; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            mem_q[wptr_q] <= in_line;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_line  = out_line_q;
    assign out_last  = out_last_q;
    assign frame_len = frame_len_q;
    assign frame_err = frame_err_q;

endmodule
